// File: rtl/line_pkg.sv
// Purpose : shared coordinate widths and line-FSM state encoding for the line-drawing path.
// Latency : n/a (constants and types only).
// Backpressure: n/a.
package line_pkg;

  localparam int XW = 10;                           // x coordinate width (unsigned)
  localparam int YW = 9;                            // y coordinate width (unsigned)
  localparam int EW = ((XW > YW) ? XW : YW) + 2;    // signed delta / error width

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    DRAW  = 2'd2
  } line_state_e;

endpackage

// File: rtl/line_octant_setup.sv
// Purpose : derives Bresenham deltas, step signs, initial error and step count from latched endpoints.
// Latency : combinational.
// Backpressure: none.
// Ports   : x0_i/y0_i/x1_i/y1_i endpoints in; dx_o, dy_o (negative), sx_o, sy_o, err0_o, steps_o out (signed EW).
module line_octant_setup
  import line_pkg::*;
(
  input  logic [XW-1:0]        x0_i,
  input  logic [YW-1:0]        y0_i,
  input  logic [XW-1:0]        x1_i,
  input  logic [YW-1:0]        y1_i,
  output logic signed [EW-1:0] dx_o,
  output logic signed [EW-1:0] dy_o,
  output logic signed [EW-1:0] sx_o,
  output logic signed [EW-1:0] sy_o,
  output logic signed [EW-1:0] err0_o,
  output logic signed [EW-1:0] steps_o
);

  localparam logic signed [EW-1:0] POS_ONE = EW'(1);
  localparam logic signed [EW-1:0] NEG_ONE = '1;

  logic signed [EW-1:0] ex0, ex1, ey0, ey1;
  logic signed [EW-1:0] abs_dy;

  // Zero-extend into the wider signed domain so differences never wrap.
  assign ex0 = $signed({{(EW-XW){1'b0}}, x0_i});
  assign ex1 = $signed({{(EW-XW){1'b0}}, x1_i});
  assign ey0 = $signed({{(EW-YW){1'b0}}, y0_i});
  assign ey1 = $signed({{(EW-YW){1'b0}}, y1_i});

  assign dx_o    = (ex1 >= ex0) ? (ex1 - ex0) : (ex0 - ex1);
  assign abs_dy  = (ey1 >= ey0) ? (ey1 - ey0) : (ey0 - ey1);
  assign dy_o    = -abs_dy;
  assign sx_o    = (x0_i < x1_i) ? POS_ONE : NEG_ONE;
  assign sy_o    = (y0_i < y1_i) ? POS_ONE : NEG_ONE;
  assign err0_o  = dx_o - abs_dy;
  assign steps_o = (dx_o >= abs_dy) ? dx_o : abs_dy;

endmodule

// File: rtl/line_fragment_generator.sv
// Purpose : latches line endpoints on start and emits one Bresenham pixel per clock, pulsing finish on the last.
// Latency : start sampled at edge T -> first valid pixel in cycle T+2; one pixel per cycle thereafter.
// Backpressure: none; the consumer must accept every pixel. start while busy is ignored.
// Ports   : clk, reset_n (async, active-low), rst_fragment (sync clear), start_fragment, x0/y0/x1/y1 in;
//           frag_x/frag_y/frag_valid/frag_gen_finish/busy out (all registered).
module line_fragment_generator
  import line_pkg::*;
(
  input  logic          clk,
  input  logic          reset_n,
  input  logic          rst_fragment,
  input  logic          start_fragment,
  input  logic [XW-1:0] x0,
  input  logic [YW-1:0] y0,
  input  logic [XW-1:0] x1,
  input  logic [YW-1:0] y1,
  output logic [XW-1:0] frag_x,
  output logic [YW-1:0] frag_y,
  output logic          frag_valid,
  output logic          frag_gen_finish,
  output logic          busy
);

  line_state_e          state_q;
  logic [XW-1:0]        x0_q, x1_q, frag_x_q;
  logic [YW-1:0]        y0_q, y1_q, frag_y_q;
  logic signed [EW-1:0] err_q, steps_q;
  logic                 frag_valid_q, finish_q, busy_q;

  logic signed [EW-1:0] dx, dy, sx, sy, err0, steps0;

  // Endpoints are latched, so these stay stable for the whole line.
  line_octant_setup u_setup (
    .x0_i    (x0_q),
    .y0_i    (y0_q),
    .x1_i    (x1_q),
    .y1_i    (y1_q),
    .dx_o    (dx),
    .dy_o    (dy),
    .sx_o    (sx),
    .sy_o    (sy),
    .err0_o  (err0),
    .steps_o (steps0)
  );

  // Next-pixel datapath: both axis decisions use the same e2 and accumulate into err.
  logic signed [EW-1:0] e2;
  logic                 step_x, step_y;
  logic signed [EW-1:0] err_d;
  logic signed [EW-1:0] x_ext_d, y_ext_d;
  logic [XW-1:0]        x_d;
  logic [YW-1:0]        y_d;

  always_comb begin
    e2      = err_q <<< 1;
    step_x  = (e2 >= dy);
    step_y  = (e2 <= dx);
    err_d   = err_q;
    x_ext_d = $signed({{(EW-XW){1'b0}}, frag_x_q});
    y_ext_d = $signed({{(EW-YW){1'b0}}, frag_y_q});
    if (step_x) begin
      err_d   = err_d + dy;
      x_ext_d = x_ext_d + sx;
    end
    if (step_y) begin
      err_d   = err_d + dx;
      y_ext_d = y_ext_d + sy;
    end
  end

  // Coordinates never leave the endpoint box, so the upper bits are always zero.
  assign x_d = x_ext_d[XW-1:0];
  assign y_d = y_ext_d[YW-1:0];

  logic unused_hi;
  assign unused_hi = ^{x_ext_d[EW-1:XW], y_ext_d[EW-1:YW]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      x0_q         <= '0;
      y0_q         <= '0;
      x1_q         <= '0;
      y1_q         <= '0;
      frag_x_q     <= '0;
      frag_y_q     <= '0;
      err_q        <= '0;
      steps_q      <= '0;
      frag_valid_q <= 1'b0;
      finish_q     <= 1'b0;
      busy_q       <= 1'b0;
    end else if (rst_fragment) begin
      state_q      <= IDLE;
      x0_q         <= '0;
      y0_q         <= '0;
      x1_q         <= '0;
      y1_q         <= '0;
      frag_x_q     <= '0;
      frag_y_q     <= '0;
      err_q        <= '0;
      steps_q      <= '0;
      frag_valid_q <= 1'b0;
      finish_q     <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          frag_valid_q <= 1'b0;
          finish_q     <= 1'b0;
          if (start_fragment) begin
            x0_q    <= x0;
            y0_q    <= y0;
            x1_q    <= x1;
            y1_q    <= y1;
            busy_q  <= 1'b1;
            state_q <= SETUP;
          end
        end
        SETUP: begin
          // Outputs are registered, so the first pixel is loaded here.
          frag_x_q     <= x0_q;
          frag_y_q     <= y0_q;
          err_q        <= err0;
          steps_q      <= steps0;
          frag_valid_q <= 1'b1;
          finish_q     <= (steps0 == '0);
          state_q      <= DRAW;
        end
        DRAW: begin
          // steps_q counts pixels still to come after the one on the outputs.
          if (steps_q == '0) begin
            frag_valid_q <= 1'b0;
            finish_q     <= 1'b0;
            busy_q       <= 1'b0;
            state_q      <= IDLE;
          end else begin
            frag_x_q     <= x_d;
            frag_y_q     <= y_d;
            err_q        <= err_d;
            steps_q      <= steps_q - EW'(1);
            frag_valid_q <= 1'b1;
            finish_q     <= (steps_q == EW'(1));
          end
        end
        default: begin
          frag_valid_q <= 1'b0;
          finish_q     <= 1'b0;
          busy_q       <= 1'b0;
          state_q      <= IDLE;
        end
      endcase
    end
  end

  assign frag_x          = frag_x_q;
  assign frag_y          = frag_y_q;
  assign frag_valid      = frag_valid_q;
  assign frag_gen_finish = finish_q;
  assign busy            = busy_q;

endmodule

// File: tb/tb_line_fragment_generator.sv
// Purpose : directed checks of line_fragment_generator pixel sequences, latency, finish, aborts and start-while-busy.
// Latency : n/a (bench).
// Backpressure: n/a (bench).
module tb_line_fragment_generator;
  import line_pkg::*;

  logic          clk;
  logic          reset_n;
  logic          rst_fragment;
  logic          start_fragment;
  logic [XW-1:0] x0, x1;
  logic [YW-1:0] y0, y1;
  logic [XW-1:0] frag_x;
  logic [YW-1:0] frag_y;
  logic          frag_valid;
  logic          frag_gen_finish;
  logic          busy;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_x[$];
  int exp_y[$];

  line_fragment_generator dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .rst_fragment    (rst_fragment),
    .start_fragment  (start_fragment),
    .x0              (x0),
    .y0              (y0),
    .x1              (x1),
    .y1              (y1),
    .frag_x          (frag_x),
    .frag_y          (frag_y),
    .frag_valid      (frag_valid),
    .frag_gen_finish (frag_gen_finish),
    .busy            (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag, input bit zeroed);
    chk({tag, " valid"},  int'(frag_valid), 0);
    chk({tag, " finish"}, int'(frag_gen_finish), 0);
    chk({tag, " busy"},   int'(busy), 0);
    if (zeroed) begin
      chk({tag, " x"}, int'(frag_x), 0);
      chk({tag, " y"}, int'(frag_y), 0);
    end
  endtask

  // Pulses start at a negedge so it is sampled by the following posedge (edge T).
  task automatic start_line(input int ax, input int ay, input int bx, input int by);
    @(negedge clk);
    x0 = XW'(ax); y0 = YW'(ay); x1 = XW'(bx); y1 = YW'(by);
    start_fragment = 1'b1;
    @(negedge clk);
    start_fragment = 1'b0;
  endtask

  // Expects exp_x/exp_y pixels on consecutive cycles starting at T+2.
  // inject_at >= 0: at that pixel pulse a second start and keep scrambling the endpoint inputs.
  task automatic run_line(input string tag, input int ax, input int ay, input int bx, input int by,
                          input int inject_at);
    int n;
    n = exp_x.size();
    start_line(ax, ay, bx, by);
    chk({tag, " setup busy"},  int'(busy), 1);
    chk({tag, " setup valid"}, int'(frag_valid), 0);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      start_fragment = 1'b0;
      chk($sformatf("%s px%0d valid", tag, i),  int'(frag_valid), 1);
      chk($sformatf("%s px%0d x", tag, i),      int'(frag_x), exp_x[i]);
      chk($sformatf("%s px%0d y", tag, i),      int'(frag_y), exp_y[i]);
      chk($sformatf("%s px%0d finish", tag, i), int'(frag_gen_finish), (i == n - 1) ? 1 : 0);
      chk($sformatf("%s px%0d busy", tag, i),   int'(busy), 1);
      if (inject_at >= 0 && i >= inject_at) begin
        start_fragment = (i == inject_at);
        x0 = XW'(i * 7);  y0 = YW'(i * 3);
        x1 = XW'(100 + i); y1 = YW'(50 + i);
      end
    end
    @(negedge clk);
    check_idle({tag, " after"}, 1'b0);
  endtask

  initial begin
    reset_n = 1'b0; rst_fragment = 1'b0; start_fragment = 1'b0;
    x0 = '0; y0 = '0; x1 = '0; y1 = '0;
    #1;
    check_idle("reset", 1'b1);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    exp_x = '{0, 1, 2, 3, 4}; exp_y = '{0, 0, 0, 0, 0};
    run_line("horiz", 0, 0, 4, 0, -1);

    exp_x = '{2, 2, 3, 3, 3}; exp_y = '{1, 2, 3, 4, 5};
    run_line("steep", 2, 1, 3, 5, -1);

    exp_x = '{5, 4, 3, 2, 1}; exp_y = '{5, 4, 4, 3, 3};
    run_line("negoct", 5, 5, 1, 3, -1);

    exp_x = '{7}; exp_y = '{7};
    run_line("point", 7, 7, 7, 7, -1);

    // rst_fragment while the 3rd pixel of a 10-pixel line is out; a start in the same cycle is ignored.
    start_line(0, 0, 9, 0);
    for (int i = 0; i < 3; i++) @(negedge clk);
    chk("rstfrag pre x", int'(frag_x), 2);
    rst_fragment = 1'b1;
    start_fragment = 1'b1;
    @(negedge clk);
    rst_fragment = 1'b0;
    start_fragment = 1'b0;
    check_idle("rstfrag", 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_idle($sformatf("rstfrag hold%0d", i), 1'b1);
    end

    // Asynchronous reset_n mid-draw.
    start_line(0, 0, 9, 0);
    for (int i = 0; i < 3; i++) @(negedge clk);
    chk("arst pre valid", int'(frag_valid), 1);
    reset_n = 1'b0;
    #1;
    check_idle("arst", 1'b1);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_idle($sformatf("arst hold%0d", i), 1'b1);
    end

    // Second start during DRAW plus changing inputs must not disturb the line.
    exp_x = '{10, 11, 12, 13, 14}; exp_y = '{2, 3, 3, 4, 4};
    run_line("busystart", 10, 2, 14, 4, 1);
    @(negedge clk);
    check_idle("busystart late", 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
